// File: rtl/memory_responder.sv
// Word-addressed 2^ADDR_BITS x 32 synchronous RAM behind a Read/Write strobe handshake.
// Latency: request sampled at E0, Done/Err and Mdatain valid in the cycle after E(WAIT_STATES+1).
// Backpressure: Busy high while an access is in flight; requests are ignored until back in IDLE.
module memory_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam int DEPTH = 1 << ADDR_BITS;
    // Counter value at which the final wait cycle ends; unused when there are no wait states.
    localparam logic [3:0] LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        is_write_q;

    logic        take_req;
    logic        reject;
    logic        finish;
    logic        in_range;

    logic [31:0] mem [0:DEPTH-1];

    // Any latched address bit at or above ADDR_BITS makes the access out of range.
    assign in_range = ((addr_q >> ADDR_BITS) == 32'd0);
    assign Busy     = (state_q != S_IDLE);

    // State and wait counter; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        take_req = 1'b0;
        reject   = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Read && Write) begin
                    reject = 1'b1;
                end else if (Read || Write) begin
                    take_req = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                finish  = 1'b1;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request latch, registered read data and the Done/Err completion pulses.
    always_ff @(posedge clk) begin
        if (!clr) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            Mdatain    <= 32'd0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Done <= finish && in_range;
            Err  <= reject || (finish && !in_range);
            if (take_req) begin
                addr_q     <= Addr;
                wdata_q    <= Wdata;
                is_write_q <= Write;
            end
            if (finish && !is_write_q) begin
                Mdatain <= in_range ? mem[addr_q[ADDR_BITS-1:0]] : 32'd0;
            end
        end
    end

    // Array write port; contents survive reset, but a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (clr && finish && is_write_q && in_range) begin
            mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

    logic clk;
    logic clr;

    // Index 0: default instance (2 wait states). Index 1: zero wait states.
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0][31:0] mdat_v;
    logic [1:0]       rd_v;
    logic [1:0]       wr_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       err_v;

    int checks = 0;
    int errors = 0;

    memory_responder #(.ADDR_BITS(9), .WAIT_STATES(2)) dut (
        .clk(clk), .clr(clr), .Addr(addr_v[0]), .Wdata(wdata_v[0]),
        .Read(rd_v[0]), .Write(wr_v[0]), .Mdatain(mdat_v[0]),
        .Busy(busy_v[0]), .Done(done_v[0]), .Err(err_v[0])
    );

    memory_responder #(.ADDR_BITS(9), .WAIT_STATES(0)) dut_nw (
        .clk(clk), .clr(clr), .Addr(addr_v[1]), .Wdata(wdata_v[1]),
        .Read(rd_v[1]), .Write(wr_v[1]), .Mdatain(mdat_v[1]),
        .Busy(busy_v[1]), .Done(done_v[1]), .Err(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on instance id; reports cycles from the sampling edge to completion
    // (-1 if it never completes), Busy samples seen, and which completion pulse fired.
    task automatic access(input int id, input bit is_wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int busy_n,
                          output logic dn, output logic er);
        addr_v[id]  = a;
        wdata_v[id] = d;
        wr_v[id]    = is_wr;
        rd_v[id]    = !is_wr;
        tick();
        rd_v[id] = 1'b0;
        wr_v[id] = 1'b0;
        lat    = -1;
        dn     = 1'b0;
        er     = 1'b0;
        busy_n = int'(busy_v[id]);
        for (int k = 1; k <= 20; k++) begin
            tick();
            busy_n += int'(busy_v[id]);
            if (done_v[id] || err_v[id]) begin
                lat = k;
                dn  = done_v[id];
                er  = err_v[id];
                break;
            end
        end
    endtask

    int   lat;
    int   bn;
    logic dn;
    logic er;

    initial begin
        addr_v  = '0;
        wdata_v = '0;
        rd_v    = '0;
        wr_v    = '0;

        // Reset held for two edges with Read asserted
        clr     = 1'b0;
        rd_v[0] = 1'b1;
        tick();
        tick();
        check("rst_mdat", mdat_v[0], 32'h0);
        check("rst_busy", {31'd0, busy_v[0]}, 32'd0);
        check("rst_done", {31'd0, done_v[0]}, 32'd0);
        check("rst_err", {31'd0, err_v[0]}, 32'd0);
        check("rst_busy_nw", {31'd0, busy_v[1]}, 32'd0);
        rd_v[0] = 1'b0;
        clr     = 1'b1;
        tick();
        tick();
        check("rst_no_access", {30'd0, busy_v[0], done_v[0]}, 32'd0);

        // Write 0x1F then read it back, two wait states
        access(0, 1'b1, 32'h1F, 32'hDEADBEEF, lat, bn, dn, er);
        check("wr_lat", lat, 3);
        check("wr_done", {31'd0, dn}, 32'd1);
        check("wr_err", {31'd0, er}, 32'd0);
        check("wr_busy_cycles", bn, 3);
        check("wr_mdat_unchanged", mdat_v[0], 32'h0);
        tick();
        check("done_one_pulse", {31'd0, done_v[0]}, 32'd0);
        access(0, 1'b0, 32'h1F, 32'h0, lat, bn, dn, er);
        check("rd_lat", lat, 3);
        check("rd_done", {31'd0, dn}, 32'd1);
        check("rd_data", mdat_v[0], 32'hDEADBEEF);

        // Zero wait states: write 5 to address 0, then read it
        access(1, 1'b1, 32'h0, 32'h5, lat, bn, dn, er);
        check("nw_wr_lat", lat, 1);
        access(1, 1'b0, 32'h0, 32'h0, lat, bn, dn, er);
        check("nw_rd_lat", lat, 1);
        check("nw_busy_cycles", bn, 1);
        check("nw_rd_data", mdat_v[1], 32'h5);
        check("nw_rd_done", {31'd0, dn}, 32'd1);

        // Read and Write together are rejected
        access(0, 1'b1, 32'h20, 32'h11111111, lat, bn, dn, er);
        addr_v[0]  = 32'h20;
        wdata_v[0] = 32'h22222222;
        rd_v[0]    = 1'b1;
        wr_v[0]    = 1'b1;
        tick();
        rd_v[0] = 1'b0;
        wr_v[0] = 1'b0;
        check("rej_err", {31'd0, err_v[0]}, 32'd1);
        check("rej_busy", {31'd0, busy_v[0]}, 32'd0);
        check("rej_done", {31'd0, done_v[0]}, 32'd0);
        check("rej_mdat", mdat_v[0], 32'hDEADBEEF);
        tick();
        check("rej_err_pulse", {30'd0, err_v[0], busy_v[0]}, 32'd0);
        access(0, 1'b0, 32'h20, 32'h0, lat, bn, dn, er);
        check("rej_old_data", mdat_v[0], 32'h11111111);

        // Out-of-range 0x200 aliases address 0 in the low bits
        access(0, 1'b1, 32'h0, 32'hA5A5A5A5, lat, bn, dn, er);
        access(0, 1'b1, 32'h200, 32'h12345678, lat, bn, dn, er);
        check("oor_wr_lat", lat, 3);
        check("oor_wr_err", {31'd0, er}, 32'd1);
        check("oor_wr_done", {31'd0, dn}, 32'd0);
        access(0, 1'b0, 32'h0, 32'h0, lat, bn, dn, er);
        check("oor_addr0_kept", mdat_v[0], 32'hA5A5A5A5);
        access(0, 1'b0, 32'h200, 32'h0, lat, bn, dn, er);
        check("oor_rd_err", {31'd0, er}, 32'd1);
        check("oor_rd_done", {31'd0, dn}, 32'd0);
        check("oor_rd_zero", mdat_v[0], 32'h0);

        // Inputs toggled during WAIT must not disturb the in-flight write
        access(0, 1'b1, 32'h41, 32'h41414141, lat, bn, dn, er);
        addr_v[0]  = 32'h40;
        wdata_v[0] = 32'hCAFEF00D;
        wr_v[0]    = 1'b1;
        tick();
        addr_v[0]  = 32'h41;
        wdata_v[0] = 32'h00000BAD;
        tick();
        wdata_v[0] = 32'h0000F00F;
        tick();
        wr_v[0] = 1'b0;
        tick();
        check("busy_toggle_done", {31'd0, done_v[0]}, 32'd1);
        tick();
        check("busy_no_extra", {30'd0, busy_v[0], done_v[0]}, 32'd0);
        access(0, 1'b0, 32'h40, 32'h0, lat, bn, dn, er);
        check("busy_orig_data", mdat_v[0], 32'hCAFEF00D);
        access(0, 1'b0, 32'h41, 32'h0, lat, bn, dn, er);
        check("busy_other_kept", mdat_v[0], 32'h41414141);

        // Reset during WAIT of a write to 0x10 aborts it
        access(0, 1'b1, 32'h10, 32'h10101010, lat, bn, dn, er);
        addr_v[0]  = 32'h10;
        wdata_v[0] = 32'hFFFF0000;
        wr_v[0]    = 1'b1;
        tick();
        wr_v[0] = 1'b0;
        tick();
        check("abort_in_wait", {31'd0, busy_v[0]}, 32'd1);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
        check("abort_mdat_rst", mdat_v[0], 32'h0);
        dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            dn = dn | done_v[0];
        end
        check("abort_no_done", {31'd0, dn}, 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, lat, bn, dn, er);
        check("abort_mem_kept", mdat_v[0], 32'h10101010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
